// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - HEAD + 11-byte payload (+ optional CRC-8) frame parser with atomic commit; CRC check built only with UART_FRAME_CRC_EN
module uart_frame_parser #(
  parameter logic [7:0] HEAD_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] uart_data,
  input  logic       uart_done,
  output logic [7:0] rev_data0,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic       pack_done,
  output logic       crc_err,
  output logic       timeout_err,
  output logic       frame_busy
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef UART_FRAME_CRC_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, CRC = 2'd2, COMMIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, COMMIT = 2'd3} state_t;
`endif

  state_t        state, next_state;
  logic [3:0]    idx;
  logic [CW-1:0] to_cnt;
  logic [7:0]    shadow [0:10];
  logic [7:0]    rev_q  [0:10];
  logic          hdr_hit, pay_wr, commit_go, to_hit;

`ifdef UART_FRAME_CRC_EN
  logic [7:0] crc_q;
  logic       crc_bad;
  logic       crc_err_q;

  // CRC-8, poly 0x07, MSB first, applied to one byte
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and per-cycle control strobes; a byte always beats a timeout
  always_comb begin
    next_state = state;
    hdr_hit    = 1'b0;
    pay_wr     = 1'b0;
    commit_go  = 1'b0;
    to_hit     = 1'b0;
`ifdef UART_FRAME_CRC_EN
    crc_bad    = 1'b0;
`endif
    case (state)
      PAYLOAD: begin
        if (uart_done) begin
          pay_wr = 1'b1;
          if (idx == 4'd10) begin
`ifdef UART_FRAME_CRC_EN
            next_state = CRC;
`else
            next_state = COMMIT;
            commit_go  = 1'b1;
`endif
          end
        end else if (to_cnt == TO_LAST) begin
          next_state = IDLE;
          to_hit     = 1'b1;
        end
      end
`ifdef UART_FRAME_CRC_EN
      CRC: begin
        if (uart_done) begin
          if (uart_data == crc_q) begin
            next_state = COMMIT;
            commit_go  = 1'b1;
          end else begin
            next_state = IDLE;
            crc_bad    = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          next_state = IDLE;
          to_hit     = 1'b1;
        end
      end
`endif
      default: begin
        // IDLE and the single COMMIT cycle both hunt for a header
        next_state = IDLE;
        if (uart_done && uart_data == HEAD_BYTE) begin
          next_state = PAYLOAD;
          hdr_hit    = 1'b1;
        end
      end
    endcase
  end

  // Datapath: shadow capture, index, timeout counter, outputs and pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx         <= '0;
      to_cnt      <= '0;
      pack_done   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        shadow[i] <= '0;
        rev_q[i]  <= '0;
      end
    end else begin
      pack_done   <= commit_go;
      timeout_err <= to_hit;
      if (hdr_hit) idx <= '0;
      if (pay_wr) begin
        shadow[idx] <= uart_data;
        idx         <= idx + 4'd1;
      end
      if (commit_go) begin
        for (int i = 0; i < 10; i++) rev_q[i] <= shadow[i];
`ifdef UART_FRAME_CRC_EN
        rev_q[10] <= shadow[10];
`else
        rev_q[10] <= uart_data;
`endif
      end
      if (uart_done || state == IDLE || state == COMMIT) to_cnt <= '0;
      else                                               to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef UART_FRAME_CRC_EN
  // Running CRC over the payload and the registered mismatch pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_bad;
      if (hdr_hit)     crc_q <= '0;
      else if (pay_wr) crc_q <= crc8_byte(crc_q, uart_data);
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign frame_busy = (state != IDLE);
  assign rev_data0  = rev_q[0];
  assign rev_data1  = rev_q[1];
  assign rev_data2  = rev_q[2];
  assign rev_data3  = rev_q[3];
  assign rev_data4  = rev_q[4];
  assign rev_data5  = rev_q[5];
  assign rev_data6  = rev_q[6];
  assign rev_data7  = rev_q[7];
  assign rev_data8  = rev_q[8];
  assign rev_data9  = rev_q[9];
  assign rev_data10 = rev_q[10];

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int         TO   = 40;
  localparam logic [7:0] HEAD = 8'hA5;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] uart_data = 8'h00;
  logic       uart_done = 1'b0;
  logic [7:0] rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
  logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
  logic       pack_done, crc_err, timeout_err, frame_busy;

  uart_frame_parser #(.HEAD_BYTE(HEAD), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_data(uart_data), .uart_done(uart_done),
    .rev_data0(rev_data0), .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3),
    .rev_data4(rev_data4), .rev_data5(rev_data5), .rev_data6(rev_data6), .rev_data7(rev_data7),
    .rev_data8(rev_data8), .rev_data9(rev_data9), .rev_data10(rev_data10),
    .pack_done(pack_done), .crc_err(crc_err), .timeout_err(timeout_err), .frame_busy(frame_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  kind;   // {timeout_err, crc_err, pack_done}
    logic [87:0] rev;
    logic [31:0] due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  int          last  = 0;
  logic [87:0] rev_exp = '0;
  logic [87:0] rev_now;

  assign rev_now = {rev_data10, rev_data9, rev_data8, rev_data7, rev_data6, rev_data5,
                    rev_data4, rev_data3, rev_data2, rev_data1, rev_data0};

  task automatic chk(input string name, input logic [87:0] got, input logic [87:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [87:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 11; i++) begin
      c = c ^ p[8*i +: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Monitor: every pulse must match the oldest expected event
  always @(negedge sys_clk) begin
    if (!sys_rst && (pack_done || crc_err || timeout_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 88'({timeout_err, crc_err, pack_done}), 88'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 88'({timeout_err, crc_err, pack_done}), 88'(e.kind));
        chk("pulse_cycle", 88'(cyc), 88'(e.due));
        chk("rev_data", rev_now, e.rev);
        chk("frame_busy", 88'(frame_busy), 88'(e.kind == 3'b001));
      end
    end
  end

  task automatic put(input logic [7:0] b);
    uart_data = b;
    uart_done = 1'b1;
    @(posedge sys_clk);
    #1;
    uart_done = 1'b0;
    last = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic frame(input logic [87:0] p, input logic [7:0] crc_byte,
                       input logic [2:0] kind, input int gap);
    put(HEAD);
    idle(gap);
    for (int i = 0; i < 11; i++) begin
      put(p[8*i +: 8]);
`ifdef UART_FRAME_CRC_EN
      idle(gap);
`else
      if (i < 10) idle(gap);
`endif
    end
`ifdef UART_FRAME_CRC_EN
    put(crc_byte);
`else
    if (crc_byte == 8'hFF) idle(0);
`endif
    if (kind == 3'b001) rev_exp = p;
    exp_q.push_back({kind, rev_exp, 32'(last)});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rev"}, rev_now, 88'd0);
    chk({tag, "_pulses"}, 88'({pack_done, crc_err, timeout_err}), 88'd0);
    chk({tag, "_busy"}, 88'(frame_busy), 88'd0);
  endtask

  logic [87:0] pa, pb, pc, pd, pz;

  initial begin
    pa = 88'h0B_0A_09_08_07_06_05_04_03_02_01;
    pb = 88'h5A_A5_A5_33_00_FF_80_7F_A5_10_C3;
    pc = 88'h11_22_33_44_55_66_77_88_99_AA_BB;
    pd = 88'hFE_DC_BA_98_76_54_32_10_0F_1E_2D;
    pz = 88'd0;

    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    idle(2);

    frame(pa, crc8(pa), 3'b001, 2);
    idle(3);

`ifdef UART_FRAME_CRC_EN
    frame(pz, 8'h01, 3'b010, 1);
    idle(3);
`endif
    frame(pz, 8'h00, 3'b001, 1);
    idle(3);

    // Abandoned frame: header plus five bytes then silence
    put(HEAD);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      put(8'h30 + 8'(i));
    end
    exp_q.push_back({3'b100, rev_exp, 32'(last + TO)});
    idle(TO + 5);

    // Leading junk then a frame carrying header-valued payload bytes
    put(8'h00);
    idle(1);
    put(8'h12);
    idle(2);
    frame(pb, crc8(pb), 3'b001, 1);
    idle(3);

    // Reset in the middle of a frame
    put(HEAD);
    for (int i = 0; i < 6; i++) put(8'h40 + 8'(i));
    sys_rst = 1'b1;
    #2;
    check_reset_outputs("midrst");
    rev_exp = '0;
    idle(1);
    sys_rst = 1'b0;
    idle(2);
    frame(pc, crc8(pc), 3'b001, 1);
    idle(3);

    // Back-to-back frames: second header lands in the COMMIT cycle
    frame(pd, crc8(pd), 3'b001, 0);
    frame(pa, crc8(pa), 3'b001, 0);
    idle(3);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    chk("pending_events", 88'(exp_q.size()), 88'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
